regfile16: RTL and testbench

REGFILE16 -- requirements
Module: regfile16

---
 rtl/cpu_pkg.sv | 9 +
 rtl/decoder4_16.sv | 17 +
 rtl/reg_en_n.sv | 32 +++
 rtl/regfile16.sv | 72 +++++++
 tb/tb_regfile16.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
package cpu_pkg;

    localparam int NUM_REGS   = 16;
    localparam int REG_ADDR_W = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/decoder4_16.sv
// 4-to-16 one-hot decoder with enable; output is all-zero when disabled.
module decoder4_16
    import cpu_pkg::*;
(
    input  logic                en,
    input  reg_addr_t           sel,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_en_n.sv
// WIDTH-bit register with load enable and asynchronous active-low clear.
module reg_en_n #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/regfile16.sv
// 16-entry, 2-read/1-write register file with a hardwired-zero entry.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile16
    import cpu_pkg::*;
#(
    parameter int          WIDTH    = 64,
    parameter logic [3:0]  ZERO_REG = 4'd15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  reg_addr_t           wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  reg_addr_t           rd_addr_a,
    input  reg_addr_t           rd_addr_b,
    output logic [WIDTH-1:0]    rd_data_a,
    output logic [WIDTH-1:0]    rd_data_b,
    output logic [NUM_REGS-1:0] wr_onehot
);

    logic [NUM_REGS-1:0] wr_sel;
    logic [NUM_REGS-1:0] wr_onehot_d;
    logic [NUM_REGS-1:0] wr_onehot_q;
    logic [WIDTH-1:0]    regs [NUM_REGS];

    decoder4_16 u_dec (
        .en     (wr_en),
        .sel    (wr_addr),
        .onehot (wr_sel)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == int'(ZERO_REG)) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_store
            reg_en_n #(.WIDTH(WIDTH)) u_reg (
                .clk   (clk),
                .rst_n (reset_n),
                .en    (wr_sel[i]),
                .d     (wr_data),
                .q     (regs[i])
            );
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr != ZERO_REG) begin
            if (wr_addr == rd_addr_a) rd_data_a = wr_data;
            if (wr_addr == rd_addr_b) rd_data_b = wr_data;
        end
`endif
    end

    // Trace copy still flags ZERO_REG writes even though the data is dropped.
    always_comb begin
        wr_onehot_d = wr_sel;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_onehot_q <= '0;
        end else begin
            wr_onehot_q <= wr_onehot_d;
        end
    end

    assign wr_onehot = wr_onehot_q;

endmodule

// File: tb/tb_regfile16.sv
// Scoreboard bench for regfile16: stimulus queues expectations, monitor checks.
module tb_regfile16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [3:0]  rd_addr_a = '0;
    logic [3:0]  rd_addr_b = '0;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic [15:0] wr_onehot;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [15:0] oh;
    } exp_t;

    exp_t exp_q[$];
    event chk_now;
    int   total = 0;
    int   bad = 0;

    regfile16 #(.WIDTH(64), .ZERO_REG(4'd15)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_onehot (wr_onehot)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are sampled mid-cycle or on an explicit async strobe.
    initial begin
        forever begin
            @(negedge clk or chk_now);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if (rd_data_a !== e.a) begin
                    bad++;
                    $display("FAIL %s rd_a got=%h want=%h", e.name, rd_data_a, e.a);
                end
                total++;
                if (rd_data_b !== e.b) begin
                    bad++;
                    $display("FAIL %s rd_b got=%h want=%h", e.name, rd_data_b, e.b);
                end
                total++;
                if (wr_onehot !== e.oh) begin
                    bad++;
                    $display("FAIL %s onehot got=%h want=%h", e.name, wr_onehot, e.oh);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] wa,
                         input logic [63:0] wd,
                         input logic [3:0] ra, input logic [3:0] rb);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr_a = ra;
        rd_addr_b = rb;
    endtask

    task automatic expect_rd(input string n, input logic [63:0] a,
                             input logic [63:0] b, input logic [15:0] oh);
        exp_t e;
        e.name = n;
        e.a    = a;
        e.b    = b;
        e.oh   = oh;
        exp_q.push_back(e);
    endtask

    localparam logic [63:0] DEAD = 64'hDEADBEEF_00000001;
`ifdef REGFILE_BYPASS_EN
    localparam logic [63:0] R7_SAME = 64'hBB;
`else
    localparam logic [63:0] R7_SAME = 64'hAA;
`endif

    initial begin
        // Reset holds; a write presented under reset must be lost
        drive(1'b1, 4'd3, 64'h77, 4'd3, 4'd0);
        #1;
        expect_rd("reset", 64'h0, 64'h0, 16'h0);
        tick();
        tick();
        reset_n = 1'b1;
        drive(1'b0, 4'd0, 64'h0, 4'd3, 4'd0);
        expect_rd("reset_wins", 64'h0, 64'h0, 16'h0);

        // First edge after release accepts the write
        tick();
        drive(1'b1, 4'd3, DEAD, 4'd3, 4'd3);
        expect_rd("r3_before", 64'h0, 64'h0, 16'h0);
        tick();
        drive(1'b0, 4'd0, 64'h0, 4'd3, 4'd3);
        expect_rd("r3_after", DEAD, DEAD, 16'h0008);

        // Zero register discards data, onehot still shows it
        tick();
        drive(1'b1, 4'd15, '1, 4'd15, 4'd3);
        tick();
        drive(1'b0, 4'd0, 64'h0, 4'd15, 4'd3);
        expect_rd("r15_zero", 64'h0, DEAD, 16'h8000);

        // No write without enable
        tick();
        drive(1'b0, 4'd5, 64'h1234, 4'd5, 4'd5);
        tick();
        expect_rd("no_wr_en", 64'h0, 64'h0, 16'h0);

        // Same-cycle read/write of r7
        drive(1'b1, 4'd7, 64'hAA, 4'd0, 4'd0);
        tick();
        drive(1'b1, 4'd7, 64'hBB, 4'd7, 4'd7);
        expect_rd("r7_same", R7_SAME, R7_SAME, 16'h0080);
        tick();
        drive(1'b0, 4'd0, 64'h0, 4'd7, 4'd7);
        expect_rd("r7_next", 64'hBB, 64'hBB, 16'h0080);

        // Sweep every writable register
        for (int i = 0; i < 15; i++) begin
            tick();
            drive(1'b1, 4'(i), 64'(i + 1), 4'd0, 4'd0);
        end
        tick();
        for (int r = 0; r < 16; r++) begin
            logic [3:0]  ra;
            logic [3:0]  rb;
            logic [63:0] ea;
            logic [63:0] eb;
            ra = 4'(r);
            rb = 4'(15 - r);
            ea = (r < 15) ? 64'(r + 1) : 64'h0;
            eb = (15 - r < 15) ? 64'(16 - r) : 64'h0;
            drive(1'b0, 4'd0, 64'h0, ra, rb);
            expect_rd($sformatf("sweep_%0d", r), ea, eb,
                      (r == 0) ? 16'h4000 : 16'h0);
            tick();
        end

        // Async reset mid-cycle with everything loaded
        drive(1'b1, 4'd9, 64'h55, 4'd0, 4'd0);
        tick();
        drive(1'b0, 4'd0, 64'h0, 4'd9, 4'd1);
        expect_rd("pre_async", 64'h55, 64'h2, 16'h0200);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        expect_rd("async_rst", 64'h0, 64'h0, 16'h0);
        ->chk_now;
        #1;
        drive(1'b0, 4'd0, 64'h0, 4'd3, 4'd7);
        #1;
        expect_rd("async_rst2", 64'h0, 64'h0, 16'h0);
        ->chk_now;
        tick();
        reset_n = 1'b1;
        drive(1'b0, 4'd0, 64'h0, 4'd14, 4'd0);
        expect_rd("post_rst", 64'h0, 64'h0, 16'h0);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
